// File: rtl/rob_param.sv
// ---------------------------------------------------------------------------
// rob_param -- reorder buffer for the out-of-order RV32I core.
//
// Entries are allocated in program order at the tail and receive results out
// of order on NUM_WB writeback channels. The head retires in order: at most
// one entry per cycle, producing a register-write commit pulse, a store
// handshake, or a branch-predictor update. A control instruction whose actual
// next pc differs from its predicted next pc flushes the whole buffer at the
// retire edge and raises a one-cycle flush pulse with the redirect target.
//
// Optional feature (compile-time macro ROB_PERF_CNT_EN):
//   defined   -> adds perf_commits / perf_flushes 32-bit wrapping counters
//   undefined -> those ports and counters do not exist
//
// Handshakes: a transfer happens on a rising clk edge where both sides of a
// pair are high and rdy=1 (alloc_valid/alloc_ready, store_valid/store_ready).
// Valid is never made dependent on ready by the producer; alloc_ready and
// store_valid are combinational from registered state only (plus rdy).
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   rdy                 global enable, low freezes all state
//   alloc_*             decoder allocation request; alloc_id = tail tag
//   wb_valid/id/value/addr   packed per-channel writeback buses (slice k)
//   commit_*            registered retire pulse and its payload
//   store_valid/addr/data, store_ready   head store handshake
//   bp_valid/pc/taken   registered predictor-update pulse
//   flush, flush_pc     registered mispredict pulse and redirect target
//   count               occupancy (0..DEPTH)
//   perf_commits, perf_flushes   (ROB_PERF_CNT_EN only) event counters
// ---------------------------------------------------------------------------
module rob_param #(
    parameter int DEPTH  = 16,
    parameter int XLEN   = 32,
    parameter int NUM_WB = 2,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    output logic [IDX_W-1:0]         alloc_id,
    input  logic [XLEN-1:0]          alloc_pc,
    input  logic [1:0]               alloc_kind,
    input  logic                     alloc_we,
    input  logic [4:0]               alloc_rd,
    input  logic [XLEN-1:0]          alloc_pred_pc,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]  wb_id,
    input  logic [NUM_WB*XLEN-1:0]   wb_value,
    input  logic [NUM_WB*XLEN-1:0]   wb_addr,
    output logic                     commit_valid,
    output logic [IDX_W-1:0]         commit_id,
    output logic                     commit_we,
    output logic [4:0]               commit_rd,
    output logic [XLEN-1:0]          commit_value,
    output logic                     store_valid,
    output logic [XLEN-1:0]          store_addr,
    output logic [XLEN-1:0]          store_data,
    input  logic                     store_ready,
    output logic                     bp_valid,
    output logic [XLEN-1:0]          bp_pc,
    output logic                     bp_taken,
    output logic                     flush,
    output logic [XLEN-1:0]          flush_pc,
    output logic [IDX_W:0]           count
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]              perf_commits,
    output logic [31:0]              perf_flushes
`endif
);

    localparam logic [1:0]       KIND_STORE = 2'b01;
    localparam logic [1:0]       KIND_CTRL  = 2'b10;
    localparam logic [IDX_W:0]   FULL_CNT   = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] ONE_IDX    = IDX_W'(1);
    localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(4);

    // Pointers and per-entry state
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] ready_n;

    logic [XLEN-1:0]  e_pc    [DEPTH];
    logic [XLEN-1:0]  e_pred  [DEPTH];
    logic [XLEN-1:0]  e_value [DEPTH];
    logic [XLEN-1:0]  e_addr  [DEPTH];
    logic [1:0]       e_kind  [DEPTH];
    logic [4:0]       e_rd    [DEPTH];
    logic [DEPTH-1:0] e_we;

    // Head decode
    logic head_ready;
    logic head_is_store;
    logic head_is_ctrl;
    logic retire_fire;
    logic mispredict;
    logic alloc_fire;
    logic wb_en;

    // Writeback decode
    logic [IDX_W-1:0]  wb_idx [NUM_WB];
    logic [NUM_WB-1:0] wb_hit;

    assign head_ready    = (count != '0) && ready[head];
    assign head_is_store = (e_kind[head] == KIND_STORE);
    assign head_is_ctrl  = (e_kind[head] == KIND_CTRL);

    // A store only leaves the head in a cycle where memory takes it.
    assign retire_fire = rdy && head_ready && (!head_is_store || store_ready);
    assign mispredict  = retire_fire && head_is_ctrl && (e_addr[head] != e_pred[head]);

    // The flush cycle (flush=1) blocks allocation and ignores writebacks so
    // nothing from the squashed path leaks into the freshly emptied buffer.
    // alloc_ready deliberately does not look ahead at a same-cycle retire.
    assign alloc_ready = (count != FULL_CNT) && !flush;
    assign alloc_fire  = rdy && alloc_valid && alloc_ready;
    assign alloc_id    = tail;
    assign wb_en       = rdy && !flush && !mispredict;

    assign store_valid = rdy && head_ready && head_is_store;
    assign store_addr  = e_addr[head];
    assign store_data  = e_value[head];

    // An entry is live when its distance from head is below the occupancy;
    // writebacks to dead slots are dropped.
    always_comb begin
        wb_idx = '{default: '0};
        wb_hit = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            wb_idx[k] = wb_id[k*IDX_W +: IDX_W];
            wb_hit[k] = wb_valid[k] && ({1'b0, IDX_W'(wb_idx[k] - head)} < count);
        end
    end

    // Ready-bit next state. Order matters: a later assignment wins, so the
    // highest-numbered writeback channel dominates and a flush clears all.
    always_comb begin
        ready_n = ready;
        if (alloc_fire) begin
            ready_n[tail] = 1'b0;
        end
        if (wb_en) begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_hit[k]) begin
                    ready_n[wb_idx[k]] = 1'b1;
                end
            end
        end
        if (retire_fire) begin
            ready_n[head] = 1'b0;
        end
        if (mispredict) begin
            ready_n = '0;
        end
    end

    // Entry payload storage; no reset needed since ready bits gate all use.
    always_ff @(posedge clk) begin
        if (alloc_fire && !mispredict) begin
            e_pc[tail]   <= alloc_pc;
            e_pred[tail] <= alloc_pred_pc;
            e_kind[tail] <= alloc_kind;
            e_rd[tail]   <= alloc_rd;
            e_we[tail]   <= alloc_we;
        end
        if (wb_en) begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_hit[k]) begin
                    e_value[wb_idx[k]] <= wb_value[k*XLEN +: XLEN];
                    e_addr[wb_idx[k]]  <= wb_addr[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Pointers, occupancy and registered retire outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ready        <= '0;
            commit_valid <= 1'b0;
            commit_id    <= '0;
            commit_we    <= 1'b0;
            commit_rd    <= '0;
            commit_value <= '0;
            bp_valid     <= 1'b0;
            bp_pc        <= '0;
            bp_taken     <= 1'b0;
            flush        <= 1'b0;
            flush_pc     <= '0;
        end else if (!rdy) begin
            commit_valid <= 1'b0;
            bp_valid     <= 1'b0;
            flush        <= 1'b0;
        end else begin
            commit_valid <= retire_fire;
            commit_we    <= retire_fire && e_we[head] && !head_is_store;
            bp_valid     <= retire_fire && head_is_ctrl;
            flush        <= mispredict;
            ready        <= ready_n;

            if (retire_fire) begin
                commit_id    <= head;
                commit_rd    <= e_rd[head];
                commit_value <= e_value[head];
            end
            if (retire_fire && head_is_ctrl) begin
                bp_pc    <= e_pc[head];
                bp_taken <= (e_addr[head] != (e_pc[head] + PC_STEP));
            end

            if (mispredict) begin
                flush_pc <= e_addr[head];
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (retire_fire) begin
                    head <= head + ONE_IDX;
                end
                if (alloc_fire) begin
                    tail <= tail + ONE_IDX;
                end
                case ({alloc_fire, retire_fire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commits <= '0;
            perf_flushes <= '0;
        end else if (rdy) begin
            if (retire_fire) begin
                perf_commits <= perf_commits + 32'd1;
            end
            if (mispredict) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_param.sv
// ---------------------------------------------------------------------------
// tb_rob_param -- directed bench for rob_param.
// Instance dut_a uses DEPTH=16, instance dut_b uses DEPTH=4 for wrap-around.
// Expected commits / predictor updates / flushes are queued by the drivers
// and popped by monitors whenever the DUT raises the matching pulse.
// ---------------------------------------------------------------------------
module tb_rob_param;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  // ---------------- dut_a signals (DEPTH=16) ----------------
  logic        alloc_valid, alloc_ready;
  logic [3:0]  alloc_id;
  logic [31:0] alloc_pc, alloc_pred_pc;
  logic [1:0]  alloc_kind;
  logic        alloc_we;
  logic [4:0]  alloc_rd;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_id;
  logic [63:0] wb_value, wb_addr;
  logic        commit_valid, commit_we;
  logic [3:0]  commit_id;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic        store_valid, store_ready;
  logic [31:0] store_addr, store_data;
  logic        bp_valid, bp_taken, flush;
  logic [31:0] bp_pc, flush_pc;
  logic [4:0]  count;

  // ---------------- dut_b signals (DEPTH=4) ----------------
  logic        alloc_valid_b, alloc_ready_b;
  logic [1:0]  alloc_id_b;
  logic [31:0] alloc_pc_b, alloc_pred_pc_b;
  logic [1:0]  alloc_kind_b;
  logic        alloc_we_b;
  logic [4:0]  alloc_rd_b;
  logic [1:0]  wb_valid_b;
  logic [3:0]  wb_id_b;
  logic [63:0] wb_value_b, wb_addr_b;
  logic        commit_valid_b, commit_we_b;
  logic [1:0]  commit_id_b;
  logic [4:0]  commit_rd_b;
  logic [31:0] commit_value_b;
  logic        store_valid_b, store_ready_b;
  logic [31:0] store_addr_b, store_data_b;
  logic        bp_valid_b, bp_taken_b, flush_b;
  logic [31:0] bp_pc_b, flush_pc_b;
  logic [2:0]  count_b;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commits, perf_flushes, perf_commits_b, perf_flushes_b;
`endif

  rob_param #(.DEPTH(16), .XLEN(XLEN), .NUM_WB(2)) dut_a (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .alloc_pc(alloc_pc), .alloc_kind(alloc_kind), .alloc_we(alloc_we),
    .alloc_rd(alloc_rd), .alloc_pred_pc(alloc_pred_pc),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_addr(wb_addr),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_we(commit_we),
    .commit_rd(commit_rd), .commit_value(commit_value),
    .store_valid(store_valid), .store_addr(store_addr), .store_data(store_data),
    .store_ready(store_ready),
    .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_taken(bp_taken),
    .flush(flush), .flush_pc(flush_pc), .count(count)
`ifdef ROB_PERF_CNT_EN
    , .perf_commits(perf_commits), .perf_flushes(perf_flushes)
`endif
  );

  rob_param #(.DEPTH(4), .XLEN(XLEN), .NUM_WB(2)) dut_b (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid_b), .alloc_ready(alloc_ready_b), .alloc_id(alloc_id_b),
    .alloc_pc(alloc_pc_b), .alloc_kind(alloc_kind_b), .alloc_we(alloc_we_b),
    .alloc_rd(alloc_rd_b), .alloc_pred_pc(alloc_pred_pc_b),
    .wb_valid(wb_valid_b), .wb_id(wb_id_b), .wb_value(wb_value_b), .wb_addr(wb_addr_b),
    .commit_valid(commit_valid_b), .commit_id(commit_id_b), .commit_we(commit_we_b),
    .commit_rd(commit_rd_b), .commit_value(commit_value_b),
    .store_valid(store_valid_b), .store_addr(store_addr_b), .store_data(store_data_b),
    .store_ready(store_ready_b),
    .bp_valid(bp_valid_b), .bp_pc(bp_pc_b), .bp_taken(bp_taken_b),
    .flush(flush_b), .flush_pc(flush_pc_b), .count(count_b)
`ifdef ROB_PERF_CNT_EN
    , .perf_commits(perf_commits_b), .perf_flushes(perf_flushes_b)
`endif
  );

  // ---------------- scoreboard ----------------
  // commit entry: {chk_data, id[3:0], we, rd[4:0], value[31:0]}
  logic [42:0] exp_q[$];
  logic [42:0] exp_qb[$];
  logic [32:0] bp_q[$];   // {pc, taken}
  logic [31:0] fl_q[$];   // flush_pc
  int n_cmp = 0;
  int n_err = 0;
  bit b_active = 1'b0;

  function automatic logic [42:0] mk(input bit chk, input logic [3:0] id, input logic we,
                                     input logic [4:0] rd, input logic [31:0] v);
    return {chk, id, we, rd, v};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got 0x%0h expected no event", name, act);
  endtask

  // Monitor for dut_a
  always @(negedge clk) begin
    logic [42:0] e;
    logic [32:0] b;
    logic [31:0] f;
    if (!rst) begin
      if (commit_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("a_commit_unexpected", {60'd0, commit_id});
        end else begin
          e = exp_q.pop_front();
          check("a_commit_id", commit_id, e[41:38]);
          check("a_commit_we", commit_we, e[37]);
          if (e[42]) begin
            check("a_commit_rd", commit_rd, e[36:32]);
            check("a_commit_value", commit_value, e[31:0]);
          end
        end
      end
      if (bp_valid) begin
        if (bp_q.size() == 0) begin
          fail_now("a_bp_unexpected", bp_pc);
        end else begin
          b = bp_q.pop_front();
          check("a_bp_pc", bp_pc, b[32:1]);
          check("a_bp_taken", bp_taken, b[0]);
        end
      end
      if (flush) begin
        if (fl_q.size() == 0) begin
          fail_now("a_flush_unexpected", flush_pc);
        end else begin
          f = fl_q.pop_front();
          check("a_flush_pc", flush_pc, f);
        end
      end
    end
  end

  // Monitor for dut_b
  always @(negedge clk) begin
    logic [42:0] e;
    if (!rst && b_active) begin
      check("b_count_bound", count_b <= 3'd4, 1);
      if (commit_valid_b) begin
        if (exp_qb.size() == 0) begin
          fail_now("b_commit_unexpected", {62'd0, commit_id_b});
        end else begin
          e = exp_qb.pop_front();
          check("b_commit_id", {2'b00, commit_id_b}, e[41:38]);
          check("b_commit_value", commit_value_b, e[31:0]);
          check("b_commit_rd", commit_rd_b, e[36:32]);
        end
      end
      if (flush_b) fail_now("b_flush_unexpected", flush_pc_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [1:0] kind, input logic we, input logic [4:0] rd,
                          input logic [31:0] pc, input logic [31:0] pred);
    alloc_valid   = 1'b1;
    alloc_kind    = kind;
    alloc_we      = we;
    alloc_rd      = rd;
    alloc_pc      = pc;
    alloc_pred_pc = pred;
    tick();
    alloc_valid   = 1'b0;
  endtask

  task automatic do_wb(input int ch, input logic [3:0] id, input logic [31:0] val,
                       input logic [31:0] addr);
    wb_valid              = 2'b00;
    wb_valid[ch]          = 1'b1;
    wb_id[ch*4 +: 4]      = id;
    wb_value[ch*32 +: 32] = val;
    wb_addr[ch*32 +: 32]  = addr;
    tick();
    wb_valid = 2'b00;
  endtask

  task automatic wait_drain_a(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && bp_q.size() == 0 && fl_q.size() == 0 && count == 0) break;
      tick();
    end
    check("a_drain_exp_q", exp_q.size(), 0);
    check("a_drain_count", count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rdy = 1'b1;
    alloc_valid = 0; alloc_pc = 0; alloc_kind = 0; alloc_we = 0; alloc_rd = 0; alloc_pred_pc = 0;
    wb_valid = 0; wb_id = 0; wb_value = 0; wb_addr = 0; store_ready = 0;
    alloc_valid_b = 0; alloc_pc_b = 0; alloc_kind_b = 0; alloc_we_b = 0; alloc_rd_b = 0;
    alloc_pred_pc_b = 0; wb_valid_b = 0; wb_id_b = 0; wb_value_b = 0; wb_addr_b = 0;
    store_ready_b = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_count", count, 0);
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_id", alloc_id, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_we", commit_we, 0);
    check("rst_commit_id", commit_id, 0);
    check("rst_commit_value", commit_value, 0);
    check("rst_bp_valid", bp_valid, 0);
    check("rst_bp_taken", bp_taken, 0);
    check("rst_flush", flush, 0);
    check("rst_flush_pc", flush_pc, 0);
    check("rst_store_valid", store_valid, 0);

    // Fill 16 entries with no writebacks
    for (int i = 0; i < 16; i++) begin
      check("fill_alloc_id", alloc_id, i);
      check("fill_alloc_ready", alloc_ready, 1);
      do_alloc(2'b00, 1'b1, 5'(i), 32'(i * 4), 32'(i * 4 + 4));
    end
    check("full_count", count, 16);
    check("full_alloc_ready", alloc_ready, 0);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    check("full_17th_count", count, 16);
    check("full_17th_tail", alloc_id, 0);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(mk(1, 4'(i), 1, 5'(i), 32'(100 + i)));
      do_wb(i % 2, 4'(i), 32'(100 + i), 32'd0);
    end
    wait_drain_a(60);

    // Out-of-order writeback: ids 0,1,2
    check("ooo_alloc_id", alloc_id, 0);
    do_alloc(2'b00, 1'b1, 5'd1, 32'h10, 32'h14);
    do_alloc(2'b00, 1'b1, 5'd2, 32'h14, 32'h18);
    do_alloc(2'b00, 1'b1, 5'd3, 32'h18, 32'h1c);
    do_wb(0, 4'd2, 32'd7, 32'd0);
    tick(); tick();
    exp_q.push_back(mk(1, 4'd0, 1, 5'd1, 32'd5));
    do_wb(0, 4'd0, 32'd5, 32'd0);
    tick(); tick(); tick();
    check("ooo_count_after_id0", count, 2);
    exp_q.push_back(mk(1, 4'd1, 1, 5'd2, 32'd9));
    exp_q.push_back(mk(1, 4'd2, 1, 5'd3, 32'd7));
    do_wb(1, 4'd1, 32'd9, 32'd0);
    tick();
    check("ooo_c1_valid", commit_valid, 1);
    check("ooo_c1_id", commit_id, 1);
    tick();
    check("ooo_c2_valid", commit_valid, 1);
    check("ooo_c2_id", commit_id, 2);
    check("ooo_c2_value", commit_value, 7);
    wait_drain_a(20);

    // Dual-channel write to the same id: channel 1 wins
    check("dual_alloc_id", alloc_id, 3);
    do_alloc(2'b00, 1'b1, 5'd4, 32'h20, 32'h24);
    exp_q.push_back(mk(1, 4'd3, 1, 5'd4, 32'hB));
    wb_valid = 2'b11;
    wb_id    = {4'd3, 4'd3};
    wb_value = {32'hB, 32'hA};
    wb_addr  = 64'd0;
    tick();
    wb_valid = 2'b00;
    wait_drain_a(20);

    // Store stall
    store_ready = 1'b0;
    do_alloc(2'b01, 1'b0, 5'd0, 32'h40, 32'h44);
    do_wb(0, 4'd4, 32'hDEAD_BEEF, 32'h1000);
    for (int i = 0; i < 3; i++) begin
      check("st_valid_held", store_valid, 1);
      check("st_addr", store_addr, 32'h1000);
      check("st_data", store_data, 32'hDEAD_BEEF);
      check("st_no_commit", commit_valid, 0);
      tick();
    end
    exp_q.push_back(mk(0, 4'd4, 0, 5'd0, 32'd0));
    store_ready = 1'b1;
    tick();
    store_ready = 1'b0;
    check("st_commit_valid", commit_valid, 1);
    check("st_commit_we", commit_we, 0);
    check("st_valid_after", store_valid, 0);
    check("st_count_after", count, 0);
    wait_drain_a(20);

    // Correctly predicted control
    exp_q.push_back(mk(1, 4'd5, 1, 5'd6, 32'h304));
    bp_q.push_back({32'h300, 1'b0});
    do_alloc(2'b10, 1'b1, 5'd6, 32'h300, 32'h304);
    do_wb(0, 4'd5, 32'h304, 32'h304);
    wait_drain_a(20);

    // Mispredict with 5 younger entries
    check("mp_alloc_id", alloc_id, 6);
    do_alloc(2'b10, 1'b1, 5'd1, 32'h100, 32'h104);
    for (int i = 0; i < 5; i++) begin
      do_alloc(2'b00, 1'b1, 5'(10 + i), 32'(32'h104 + i * 4), 32'(32'h108 + i * 4));
    end
    for (int i = 0; i < 5; i++) begin
      do_wb(i % 2, 4'(7 + i), 32'(32'h50 + i), 32'd0);
    end
    exp_q.push_back(mk(1, 4'd6, 1, 5'd1, 32'h104));
    bp_q.push_back({32'h100, 1'b1});
    fl_q.push_back(32'h200);
    do_wb(1, 4'd6, 32'h104, 32'h200);
    // Alloc and writeback presented in the retire cycle are discarded
    alloc_valid = 1'b1; alloc_kind = 2'b00; alloc_we = 1'b1; alloc_rd = 5'd20;
    wb_valid = 2'b01; wb_id[3:0] = 4'd7; wb_value[31:0] = 32'h99;
    tick();
    check("mp_flush", flush, 1);
    check("mp_flush_pc", flush_pc, 32'h200);
    check("mp_bp_valid", bp_valid, 1);
    check("mp_bp_taken", bp_taken, 1);
    check("mp_count", count, 0);
    check("mp_alloc_ready", alloc_ready, 0);
    check("mp_commit_id", commit_id, 6);
    // Still presenting during the flush cycle: blocked / ignored
    wb_id[3:0] = 4'd0;
    tick();
    alloc_valid = 1'b0;
    wb_valid = 2'b00;
    check("mp_flush_drop", flush, 0);
    check("mp_count_post", count, 0);
    check("mp_alloc_ready_post", alloc_ready, 1);
    check("mp_tail_post", alloc_id, 0);
    do_alloc(2'b00, 1'b1, 5'd21, 32'h200, 32'h204);
    tick(); tick(); tick();
    check("mp_new_not_ready", count, 1);
    exp_q.push_back(mk(1, 4'd0, 1, 5'd21, 32'h77));
    do_wb(0, 4'd0, 32'h77, 32'd0);
    wait_drain_a(20);

    // rdy=0 freezes retirement
    do_alloc(2'b00, 1'b1, 5'd9, 32'h500, 32'h504);
    exp_q.push_back(mk(1, 4'd1, 1, 5'd9, 32'h55));
    do_wb(0, 4'd1, 32'h55, 32'd0);
    rdy = 1'b0;
    tick();
    check("frz_commit_valid_1", commit_valid, 0);
    check("frz_count_1", count, 1);
    tick();
    check("frz_commit_valid_2", commit_valid, 0);
    check("frz_count_2", count, 1);
    rdy = 1'b1;
    tick();
    check("frz_resume_valid", commit_valid, 1);
    check("frz_resume_value", commit_value, 32'h55);
    wait_drain_a(20);

    // Wrap on DEPTH=4: alloc entry i while writing back entry i-1
    b_active = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      alloc_valid_b = 1'b0;
      wb_valid_b    = 2'b00;
      if (i < 40) begin
        check("b_alloc_id", alloc_id_b, i % 4);
        alloc_valid_b   = 1'b1;
        alloc_kind_b    = 2'b00;
        alloc_we_b      = 1'b1;
        alloc_rd_b      = 5'(i % 32);
        alloc_pc_b      = 32'(i * 4);
        alloc_pred_pc_b = 32'(i * 4 + 4);
      end
      if (i > 0) begin
        wb_valid_b[i % 2]               = 1'b1;
        wb_id_b[(i % 2) * 2 +: 2]       = 2'((i - 1) % 4);
        wb_value_b[(i % 2) * 32 +: 32]  = 32'(1000 + i - 1);
        wb_addr_b[(i % 2) * 32 +: 32]   = 32'd0;
        exp_qb.push_back(mk(1, 4'((i - 1) % 4), 1, 5'((i - 1) % 32), 32'(1000 + i - 1)));
      end
      tick();
    end
    alloc_valid_b = 1'b0;
    wb_valid_b    = 2'b00;
    for (int i = 0; i < 20; i++) begin
      if (exp_qb.size() == 0 && count_b == 0) break;
      tick();
    end
    check("b_drain_exp_q", exp_qb.size(), 0);
    check("b_drain_count", count_b, 0);
    b_active = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer for the out-of-order RV32I core.
- Allocates entries in program order from the decoder and accepts results on NUM_WB writeback channels.
- Retires in order at the head: register writes, store handshakes, branch-predictor updates.
- Issues a single-cycle flush on control mispredict.

Parameters:
DEPTH, 16, entry count; power of two, >=4; IDX_W = $clog2(DEPTH) derived localparam
XLEN, 32, data/address width
NUM_WB, 2, writeback channels; channel k occupies slice k of each packed wb_* bus

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; low freezes all state
alloc_valid  in  1  decoder requests entry
alloc_ready  out  1  entry available (combinational)
alloc_id  out  IDX_W  tag of entry allocated on handshake (=tail)
alloc_pc  in  XLEN  instruction pc
alloc_kind  in  2  00 plain, 01 store, 10 control, 11 reserved-as-plain
alloc_we  in  1  entry writes rd
alloc_rd  in  5  destination register
alloc_pred_pc  in  XLEN  predicted next pc (pc+4 if not taken)
wb_valid  in  NUM_WB  per-channel result valid
wb_id  in  NUM_WB*IDX_W  entry tags
wb_value  in  NUM_WB*XLEN  result / store data
wb_addr  in  NUM_WB*XLEN  actual next pc (control) or address (store)
commit_valid  out  1  registered retire pulse
commit_id  out  IDX_W  retired tag
commit_we  out  1  write rd
commit_rd  out  5  register
commit_value  out  XLEN  value
store_valid  out  1  head is ready store (combinational)
store_addr  out  XLEN  head store address
store_data  out  XLEN  head store data
store_ready  in  1  memory accepts store
bp_valid  out  1  registered predictor-update pulse
bp_pc  out  XLEN  control instruction pc
bp_taken  out  1  actual next pc != pc+4
flush  out  1  registered mispredict pulse
flush_pc  out  XLEN  redirect target
count  out  IDX_W+1  occupancy

Behaviour:
- Circular buffer: head, tail, count; pointers wrap DEPTH-1 -> 0 naturally (IDX_W bits).
- Reset: head=tail=0, count=0, all ready bits 0. Outputs: commit_valid, bp_valid, flush, commit_we, bp_taken = 0; commit_id, commit_rd, commit_value, bp_pc, flush_pc = 0.
- alloc_ready = (count != DEPTH) && !flush_pending. Alloc on alloc_valid && alloc_ready:
  - write entry at tail, clear its ready bit;
  - tail+1.
- Writeback: for each channel with wb_valid, set ready, store value/addr at wb_id. Same-cycle writes to the same id: highest channel index wins. Writes to unallocated entries are ignored.
- Result visibility: result written at edge N is retirable in cycle N+1; commit_* pulse appears after edge N+1.
- Retire condition: count!=0 && ready[head]. At most one retire per cycle.
  - Plain: retire unconditionally.
  - Control: retire; bp_valid pulse; mispredict when wb_addr != pred_pc.
  - Store: retire only in a cycle with store_ready=1. commit_valid pulses with commit_we=0. store_valid stays high until accepted.
- Alloc and retire in the same cycle: count unchanged. Full with retire: alloc still refused (alloc_ready does not look ahead).
- Mispredict on retire, same edge:
  - head=tail=0, count=0, ready bits cleared;
  - flush=1, flush_pc=actual pc;
  - commit pulse for the control entry itself (rd write if alloc_we).
  Allocs and writebacks presented in that cycle are discarded. One-cycle flush, no extra bubble state.
- flush_pending: the cycle in which flush=1. Alloc is blocked; writebacks are ignored.
- rdy=0: no state change; registered pulses drop to 0; store_valid forced 0.
- rst has priority over everything, including a pending flush.

Optional Feature:
ROB_PERF_CNT_EN defined:
- adds outputs perf_commits (32) and perf_flushes (32);
- both reset to 0, increment on each retire / flush, wrap at 2^32.
Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Fill: DEPTH=16, 16 allocs, no wb -> alloc_ready=0, count=16, alloc_id sequence 0..15; 17th alloc ignored.
- Out-of-order wb: alloc ids 0,1,2; wb id2 value 7, then id0 value 5 -> commit id0 (value 5); id2 is not committed before id1 is written. Write id1 -> ids 1 and 2 commit on consecutive cycles.
- Dual-channel same cycle: ch0 id3=0xA, ch1 id3=0xB -> committed value 0xB.
- Store stall: head store ready, store_ready=0 for 3 cycles -> store_valid held, no commit. store_ready=1 -> commit_valid with commit_we=0 next cycle.
- Mispredict: control pc=0x100, pred 0x104, actual 0x200, 5 younger entries -> flush=1, flush_pc=0x200, bp_taken=1, count=0 next cycle; younger entries never commit.
- Wrap: 40 alloc/retire pairs with DEPTH=4 -> tags wrap 3->0, count stays <=4, all commits in order.
